btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
- Input front-end for the LED CPU programming path. It sits directly upstream of the switch/enter program loader that writes 16-bit words into program RAM.
- Synchronizes and debounces the raw ENTER push-button and synchronizes the 8 data switches.
- Outputs a clean level, single-cycle press and release pulses, and a switch snapshot that is stable at every press.
- btn_level drives the loader's enter input; sw_captured drives its switch input.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to accept a level change (>=2; board build uses 1_000_000 at 100 MHz).
- BTN_ACTIVE_HIGH, 1, 1: pressed = btn_raw high; 0: pressed = btn_raw low.
- REPEAT_DELAY, 16, auto-repeat: cycles held after the initial press before the first repeat pulse (only with the optional feature).
- REPEAT_PERIOD, 8, auto-repeat: cycles between repeat pulses (only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_raw  in  1  raw, bouncy, asynchronous push-button
- sw_raw  in  8  raw asynchronous switches
- btn_level  out  1  debounced pressed level (1 = pressed)
- btn_press  out  1  one-cycle pulse on accepted press (and on repeats)
- btn_release  out  1  one-cycle pulse on accepted release
- sw_captured  out  8  synchronized switch value sampled in the btn_press cycle

Behaviour:
- Reset (rst_n=0, async) forces:
  - state IDLE, counters 0, btn_level 0, btn_press 0, btn_release 0, sw_captured 0x00;
  - sync flops to the "released" value, so there is no spurious press after reset.
- Synchronization: btn_raw and each sw_raw bit pass through a 2-FF synchronizer. The button is polarity-normalized after sync, so s = 1 means pressed.
- FSM states:
  - IDLE: btn_level=0. If s=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT: if s=0, return to IDLE and clear cnt. Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED; else cnt++.
  - PRESSED: btn_level=1. If s=0, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT: if s=1, return to PRESSED and clear cnt. Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE; else cnt++.
- Outputs are registered:
  - btn_press=1 for exactly the first cycle btn_level=1 after PRESS_WAIT.
  - btn_release=1 for exactly the first cycle btn_level=0 after RELEASE_WAIT.
- Latency: raw edge sampled at edge k gives btn_level/btn_press high in cycle k+2+DEBOUNCE_CYCLES. Release latency is identical.
- Glitch rule: any single-cycle reversal of s during a WAIT state restarts qualification from zero. Bounce shorter than DEBOUNCE_CYCLES never changes btn_level.
- sw_captured loads the synchronized switches on the same edge that raises btn_press and holds otherwise. Switch changes while the button is held do not affect it.
- btn_press and btn_release are never high in the same cycle.
- Counter width is clog2(DEBOUNCE_CYCLES); counters saturate and never wrap.
- Reset mid-qualification abandons it: no pulse is emitted and outputs go to reset values immediately.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- When defined:
  - while in PRESSED, a hold counter runs;
  - btn_press re-pulses after REPEAT_DELAY cycles of hold, then every REPEAT_PERIOD cycles;
  - sw_captured is re-sampled on each repeat pulse;
  - the hold counter clears on leaving PRESSED;
  - btn_level is unaffected.
- When undefined: exactly one btn_press per accepted press; no hold counter is synthesized.

Decomposition:
- Package btn_cond_pkg:
  - FSM state encoding (IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3);
  - SW_WIDTH=8;
  - counter-width helper function.
- Sub-module sync_2ff (parameterized width, reset value), instantiated once for the button and once for the switch bus.

Test Plan:
- Reset with btn_raw held pressed (=1): after rst_n rises, btn_level rises at cycle 2+4=6, single btn_press, sw_captured = sw_raw = 0xA5.
- Bounce 1,0,1,0 for 1 cycle each, then steady 1: btn_press exactly once, 6 cycles after the final rising edge; no pulse during bounce.
- Press with sw_raw=0x3C, change sw_raw to 0xFF while held: sw_captured stays 0x3C; release gives one btn_release 6 cycles after the falling edge.
- Release glitch of 3 cycles (< DEBOUNCE_CYCLES=4) while pressed: btn_level stays 1; no btn_release, no second btn_press.
- Assert rst_n=0 during PRESS_WAIT (cnt=2): outputs 0 immediately, no pulse; a clean press after reset behaves normally.
- With BTN_AUTOREPEAT_EN, hold 60 cycles: btn_press pulses at t0, t0+16, t0+24, t0+32, t0+40, t0+48, t0+56. Without the macro, only t0.

Source files
------------

// File: rtl/btn_conditioner_pkg.sv
// ============================================================================
// btn_cond_pkg
//   Shared definitions for the button/switch input conditioner.
//   - btn_state_e : debounce FSM state encoding
//   - SW_WIDTH    : width of the data-switch bus
//   - cnt_width() : bits needed to count 0..n-1 (minimum 1)
//   - max_int()   : larger of two integers, for sizing shared counters
// Revision: 1.0
// ============================================================================
`default_nettype none

package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int SW_WIDTH = 8;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = (n <= 1) ? 1 : $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_conditioner_sync_2ff.sv
// ============================================================================
// sync_2ff
//   Two-flop synchronizer for asynchronous inputs, with a per-instance reset
//   value so that the synchronized output starts in a known, benign state.
//
//   Parameters: WIDTH   - number of independent bits
//               RST_VAL - value of both flop stages while rst_n is low
//   Ports:      clk     - destination clock
//               rst_n   - asynchronous active-low reset
//               d       - asynchronous input
//               q       - synchronized output (two clk cycles of latency)
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================================
// btn_conditioner
//   Front-end for the switch/enter program loader. Synchronizes and debounces
//   the ENTER push-button, synchronizes the data switches, and produces a
//   clean pressed level, single-cycle press/release pulses, and a switch
//   snapshot taken in the press cycle.
//
//   Optional build macro: BTN_AUTOREPEAT_EN
//     Defined   - while held, btn_press re-pulses after REPEAT_DELAY cycles and
//                 then every REPEAT_PERIOD cycles; sw_captured is re-sampled
//                 on each repeat.
//     Undefined - exactly one btn_press per accepted press; no hold counter.
//
//   Ports:
//     clk         in   1  system clock, rising edge
//     rst_n       in   1  asynchronous active-low reset
//     btn_raw     in   1  raw bouncy push-button
//     sw_raw      in   8  raw asynchronous switches
//     btn_level   out  1  debounced pressed level (1 = pressed)
//     btn_press   out  1  one-cycle pulse on accepted press (and repeats)
//     btn_release out  1  one-cycle pulse on accepted release
//     sw_captured out  8  synchronized switches sampled in the btn_press cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit BTN_ACTIVE_HIGH = 1'b1,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic                btn_level,
  output logic                btn_press,
  output logic                btn_release,
  output logic [SW_WIDTH-1:0] sw_captured
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // --------------------------------------------------------------------------
  // Synchronizers. The button resets to its released raw level so that a
  // board with an inverted button does not see a press right after reset.
  // --------------------------------------------------------------------------
  logic                btn_sync;
  logic [SW_WIDTH-1:0] sw_sync;
  logic                s;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'(!BTN_ACTIVE_HIGH))
  ) u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_raw),
    .q     (btn_sync)
  );

  sync_2ff #(
    .WIDTH   (SW_WIDTH),
    .RST_VAL ('0)
  ) u_sw_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw_raw),
    .q     (sw_sync)
  );

  // Polarity-normalized: s = 1 means pressed.
  assign s = BTN_ACTIVE_HIGH ? btn_sync : ~btn_sync;

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  btn_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode. Outputs are registered from the current state, so the
  // registered btn_level lags the state by one cycle. That lag is what
  // identifies the edges: PRESSED with btn_level still 0 is the first pressed
  // cycle, IDLE with btn_level still 1 is the first released cycle. A glitch
  // back from RELEASE_WAIT to PRESSED keeps btn_level at 1 and so never
  // produces a second press.
  // --------------------------------------------------------------------------
  logic level_d;
  logic first_press;
  logic release_d;
  logic press_d;

  assign level_d     = (state == PRESSED) || (state == RELEASE_WAIT);
  assign first_press = (state == PRESSED) && !btn_level;
  assign release_d   = (state == IDLE) && btn_level;

`ifdef BTN_AUTOREPEAT_EN
  // Hold counter: runs only while settled in PRESSED after the initial press
  // cycle. rep_phase selects the initial delay or the repeat period.
  localparam int            HW        = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [HW-1:0] DELAY_LIM = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PER_LIM   = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_cnt;
  logic          rep_phase;
  logic          holding;
  logic          rep_fire;
  logic [HW-1:0] hold_lim;

  assign holding  = (state == PRESSED) && btn_level;
  assign hold_lim = rep_phase ? PER_LIM : DELAY_LIM;
  assign rep_fire = holding && (hold_cnt == hold_lim);
  assign press_d  = first_press | rep_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      rep_phase <= 1'b0;
    end else if (!holding) begin
      hold_cnt  <= '0;
      rep_phase <= 1'b0;
    end else if (rep_fire) begin
      hold_cnt  <= '0;
      rep_phase <= 1'b1;
    end else begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end
`else
  assign press_d = first_press;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      sw_captured <= '0;
    end else begin
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      if (press_d) begin
        sw_captured <= sw_sync;
      end
    end
  end

endmodule

`default_nettype wire
